// File: rtl/fan_pwm_ramp_ctrl_if.sv
// Control/status bundle between the fan FSM/timer (master) and the PWM ramp controller (slave).
interface fan_pwm_ramp_ctrl_if #(
  parameter int CNT_WIDTH = 10
);
  logic                 i_cnt_en;
  logic                 i_enable;
  logic [1:0]           i_level;
  logic                 o_pwm;
  logic [CNT_WIDTH-1:0] o_duty;
  logic                 o_ramping;
  logic                 o_period_tick;

  modport master (
    output i_cnt_en, i_enable, i_level,
    input  o_pwm, o_duty, o_ramping, o_period_tick
  );

  modport slave (
    input  i_cnt_en, i_enable, i_level,
    output o_pwm, o_duty, o_ramping, o_period_tick
  );
endinterface

// File: rtl/fan_pwm_ramp_ctrl.sv
// Fan PWM generator with level-mapped duty and period-boundary ramping toward the target.
// Optional kick-start (full-on burst before the first nonzero duty) enabled by FAN_PWM_KICKSTART_EN.
module fan_pwm_ramp_ctrl #(
  parameter int CNT_WIDTH    = 10,
  parameter int PERIOD       = 1000,
  parameter int DUTY_L1      = 222,
  parameter int DUTY_L2      = 444,
  parameter int DUTY_L3      = 666,
  parameter int RAMP_STEP    = 111,
  parameter int KICK_PERIODS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  fan_pwm_ramp_ctrl_if.slave   bus
);

  // Duty is one bit wider than the counter so that duty == PERIOD == 2^CNT_WIDTH is representable.
  localparam int DW = CNT_WIDTH + 1;
  localparam int STEP_CLAMP = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(PERIOD - 1);
  localparam logic [DW-1:0]        STEP      = DW'(STEP_CLAMP);

  if (PERIOD < 2 || PERIOD > (1 << CNT_WIDTH) || KICK_PERIODS < 0) begin : g_bad_param
    $error("fan_pwm_ramp_ctrl: PERIOD or KICK_PERIODS out of range");
  end

`ifdef FAN_PWM_KICKSTART_EN
  localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [KW-1:0] KICK_LAST  = KW'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);
  localparam logic [DW-1:0] DUTY_FULL  = DW'(PERIOD);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, KICK = 2'd3} state_t;
  logic [KW-1:0] kick_cnt_reg;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;
`endif

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [DW-1:0]        duty_reg;
  state_t               state_reg;
  logic                 pwm_reg;
  logic                 ramping_reg;
  logic                 tick_reg;

  // Per-level duty table, clamped so no level can exceed a full period.
  logic [DW-1:0] level_duty [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_level
    localparam int RAW     = (gi == 0) ? 0 : (gi == 1) ? DUTY_L1 : (gi == 2) ? DUTY_L2 : DUTY_L3;
    localparam int CLAMPED = (RAW > PERIOD) ? PERIOD : RAW;
    assign level_duty[gi] = DW'(CLAMPED);
  end

  logic          wrap;
  logic [DW-1:0] target;
  logic [DW-1:0] gap;
  logic [DW-1:0] duty_step;
  state_t        state_step;

  // Step toward target using the distance rather than duty+/-step, so nothing can wrap.
  always_comb begin
    wrap      = bus.i_cnt_en && (cnt_reg == CNT_LAST);
    target    = bus.i_enable ? level_duty[bus.i_level] : '0;
    gap       = '0;
    duty_step = duty_reg;
    if (STEP_CLAMP == 0) begin
      duty_step = target;
    end else if (target > duty_reg) begin
      gap       = target - duty_reg;
      duty_step = (gap > STEP) ? duty_reg + STEP : target;
    end else if (target < duty_reg) begin
      gap       = duty_reg - target;
      duty_step = (gap > STEP) ? duty_reg - STEP : target;
    end

    if (duty_step == target) begin
      state_step = IDLE;
    end else if (target > duty_step) begin
      state_step = UP;
    end else begin
      state_step = DOWN;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg      <= '0;
      duty_reg     <= '0;
      state_reg    <= IDLE;
      pwm_reg      <= 1'b0;
      ramping_reg  <= 1'b0;
      tick_reg     <= 1'b0;
`ifdef FAN_PWM_KICKSTART_EN
      kick_cnt_reg <= '0;
`endif
    end else begin
      tick_reg <= wrap;
      if (bus.i_cnt_en) begin
        cnt_reg <= wrap ? '0 : cnt_reg + CNT_WIDTH'(1);
      end

      if (!bus.i_enable) begin
        // Immediate shutdown; the counter keeps running so period ticks continue.
        duty_reg     <= '0;
        state_reg    <= IDLE;
        pwm_reg      <= 1'b0;
        ramping_reg  <= 1'b0;
`ifdef FAN_PWM_KICKSTART_EN
        kick_cnt_reg <= '0;
`endif
      end else begin
        // Compare against the pre-wrap duty so a duty change never produces a runt pulse.
        if (bus.i_cnt_en) begin
          pwm_reg <= ({1'b0, cnt_reg} < duty_reg);
        end

        if (wrap) begin
`ifdef FAN_PWM_KICKSTART_EN
          if (state_reg == KICK) begin
            if (kick_cnt_reg == '0) begin
              duty_reg    <= target;
              state_reg   <= IDLE;
              ramping_reg <= 1'b0;
            end else begin
              kick_cnt_reg <= kick_cnt_reg - KW'(1);
            end
          end else if (duty_reg == '0 && target != '0) begin
            duty_reg     <= DUTY_FULL;
            state_reg    <= KICK;
            ramping_reg  <= 1'b1;
            kick_cnt_reg <= KICK_LAST;
          end else
`endif
          begin
            duty_reg    <= duty_step;
            state_reg   <= state_step;
            ramping_reg <= (state_step != IDLE);
          end
        end
      end
    end
  end

  // Saturate the narrower status view when duty is exactly 2^CNT_WIDTH.
  assign bus.o_duty        = duty_reg[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : duty_reg[CNT_WIDTH-1:0];
  assign bus.o_pwm         = pwm_reg;
  assign bus.o_ramping     = ramping_reg;
  assign bus.o_period_tick = tick_reg;

endmodule

// File: tb/tb_fan_pwm_ramp_ctrl.sv
// Directed bench for fan_pwm_ramp_ctrl: three instances (step jump, ramp, full-duty level) on PERIOD=10.
// With FAN_PWM_KICKSTART_EN defined it runs the kick-start sequence instead of the ramp timeline.
module tb_fan_pwm_ramp_ctrl;
  localparam int CW  = 4;
  localparam int PER = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fan_pwm_ramp_ctrl_if #(.CNT_WIDTH(CW)) if_a ();
  fan_pwm_ramp_ctrl_if #(.CNT_WIDTH(CW)) if_b ();
  fan_pwm_ramp_ctrl_if #(.CNT_WIDTH(CW)) if_c ();

  fan_pwm_ramp_ctrl #(.CNT_WIDTH(CW), .PERIOD(PER), .DUTY_L1(2), .DUTY_L2(4), .DUTY_L3(6),
                      .RAMP_STEP(0), .KICK_PERIODS(2))
    u_a (.i_clk(clk), .i_reset_n(rst_n), .bus(if_a));
  fan_pwm_ramp_ctrl #(.CNT_WIDTH(CW), .PERIOD(PER), .DUTY_L1(2), .DUTY_L2(4), .DUTY_L3(6),
                      .RAMP_STEP(3), .KICK_PERIODS(2))
    u_b (.i_clk(clk), .i_reset_n(rst_n), .bus(if_b));
  fan_pwm_ramp_ctrl #(.CNT_WIDTH(CW), .PERIOD(PER), .DUTY_L1(2), .DUTY_L2(4), .DUTY_L3(PER),
                      .RAMP_STEP(0), .KICK_PERIODS(2))
    u_c (.i_clk(clk), .i_reset_n(rst_n), .bus(if_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_duty_b(input int k);
    if (k < 30) return 0;
    if (k < 40) return 3;
    if (k < 50) return 2;
    if (k < 60) return 5;
    if (k < 64) return 6;
    return 0;
  endfunction

  initial begin
    if_a.i_cnt_en = 1'b0; if_a.i_enable = 1'b0; if_a.i_level = 2'd0;
    if_b.i_cnt_en = 1'b0; if_b.i_enable = 1'b0; if_b.i_level = 2'd0;
    if_c.i_cnt_en = 1'b0; if_c.i_enable = 1'b0; if_c.i_level = 2'd0;

    repeat (3) step();
    check("rst pwm_a",  if_a.o_pwm, 0);
    check("rst duty_a", if_a.o_duty, 0);
    check("rst ramp_a", if_a.o_ramping, 0);
    check("rst tick_a", if_a.o_period_tick, 0);
    check("rst duty_b", if_b.o_duty, 0);
    check("rst duty_c", if_c.o_duty, 0);

    @(negedge clk);
    rst_n = 1'b1;
    if_a.i_cnt_en = 1'b1; if_a.i_enable = 1'b1;
    if_b.i_cnt_en = 1'b1; if_b.i_enable = 1'b1; if_b.i_level = 2'd0;
    if_c.i_cnt_en = 1'b1; if_c.i_enable = 1'b1; if_c.i_level = 2'd3;

`ifdef FAN_PWM_KICKSTART_EN
    if_a.i_level = 2'd1;
    // Kick from W at edge 10 through W at edge 30, then duty 2 directly.
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("kick pwm_a@%0d", k),  if_a.o_pwm, (k >= 11 && k <= 32));
      check($sformatf("kick duty_a@%0d", k), if_a.o_duty, (k < 10) ? 0 : (k < 30) ? PER : 2);
      check($sformatf("kick ramp_a@%0d", k), if_a.o_ramping, (k >= 10 && k < 30));
    end
`else
    if_a.i_level = 2'd2;
    for (int k = 1; k <= 85; k++) begin
      step();
      // A: step-0 jump to level 2 (4), mid-period level glitch ignored, then level 0
      if (k <= 50) begin
        check($sformatf("pwm_a@%0d", k),  if_a.o_pwm, (k >= 11 && k <= 40 && ((k - 11) % 10) < 4));
        check($sformatf("duty_a@%0d", k), if_a.o_duty, (k >= 10 && k < 40) ? 4 : 0);
      end
      if (k <= 20) check($sformatf("tick_a@%0d", k), if_a.o_period_tick, (k == 10 || k == 20));
      // C: duty == PERIOD is constant high; toggled cnt_en doubles the period
      if (k <= 30) begin
        check($sformatf("pwm_c@%0d", k),  if_c.o_pwm, (k >= 11));
        check($sformatf("duty_c@%0d", k), if_c.o_duty, (k >= 10) ? PER : 0);
      end
      if (k >= 31 && k <= 72) begin
        check($sformatf("tick_c@%0d", k), if_c.o_period_tick, (k == 50 || k == 70));
        check($sformatf("pwm_c@%0d", k),  if_c.o_pwm, 1);
      end
      // B: ramp 0->3, reversal to 2, up 5->6, then enable drop
      check($sformatf("duty_b@%0d", k), if_b.o_duty, exp_duty_b(k));
      check($sformatf("ramp_b@%0d", k), if_b.o_ramping, ((k >= 30 && k < 40) || (k >= 50 && k < 60)));
      if (k >= 61 && k <= 63) check($sformatf("pwm_b@%0d", k), if_b.o_pwm, 1);
      if (k >= 64) begin
        check($sformatf("pwm_b@%0d", k),  if_b.o_pwm, 0);
        check($sformatf("tick_b@%0d", k), if_b.o_period_tick, (k == 70 || k == 80));
      end

      case (k)
        20: if_b.i_level = 2'd3;
        21: if_a.i_level = 2'd3;
        25: if_a.i_level = 2'd2;
        30: begin if_a.i_level = 2'd0; if_b.i_level = 2'd1; end
        40: if_b.i_level = 2'd3;
        63: if_b.i_enable = 1'b0;
        default: ;
      endcase
      if (k >= 30) if_c.i_cnt_en = (k % 2 == 1);
    end

    // Asynchronous reset mid-period while C is driving full duty.
    #2 rst_n = 1'b0;
    #1;
    check("arst pwm_c",  if_c.o_pwm, 0);
    check("arst duty_c", if_c.o_duty, 0);
    check("arst ramp_c", if_c.o_ramping, 0);
    check("arst tick_c", if_c.o_period_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    if_c.i_cnt_en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      check($sformatf("post-rst tick_c@%0d", j), if_c.o_period_tick, (j == 10));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fan_pwm_ramp_ctrl.md
Name: fan_pwm_ramp_ctrl

Overview:
Parametrised fan PWM generator that owns its period counter, maps a level select onto programmable duty thresholds, and ramps duty toward the target in fixed steps, updating only at period boundaries so there are no glitches. It is the next generation of the fixed 4-threshold fan comparator. It sits between the fan FSM/timer (which drives i_level and i_enable) and the fan motor output pin.

Parameters:
CNT_WIDTH, 10, counter/duty width in bits
PERIOD, 1000, counts per PWM period; legal range 2..2^CNT_WIDTH
DUTY_L1, 222, duty count for level 1 (level 0 is fixed at 0)
DUTY_L2, 444, duty count for level 2
DUTY_L3, 666, duty count for level 3
RAMP_STEP, 111, maximum duty change per period; 0 means jump directly to target
KICK_PERIODS, 3, kick-start length in periods (used only with the optional feature)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_cnt_en  input  1  counter advance strobe (prescaler tick); counter holds when low
i_enable  input  1  fan enable; low forces immediate off
i_level  input  2  requested fan level, 0..3
o_pwm  output  1  registered PWM output
o_duty  output  CNT_WIDTH  duty count currently applied
o_ramping  output  1  high while applied duty differs from target
o_period_tick  output  1  one-cycle pulse on each period wrap

Behaviour:
- Reset (async assert, sync release) sets cnt=0, duty=0, o_pwm=0, o_ramping=0, o_period_tick=0, state=IDLE.
- Counter: on i_cnt_en, cnt increments; at cnt==PERIOD-1 it wraps to 0. Wrap event W = i_cnt_en && cnt==PERIOD-1.
- o_period_tick is registered and equals W delayed one cycle.
- Target is combinational from i_level: 0, DUTY_L1, DUTY_L2 or DUTY_L3, clamped to PERIOD. Target is forced to 0 when i_enable=0.
- Duty updates only on W (new value takes effect with cnt=0):
  - RAMP_STEP=0: duty <= target.
  - target>duty: duty <= min(duty+RAMP_STEP, target).
  - target<duty: duty <= max(duty-RAMP_STEP, target), computed without underflow.
- Arithmetic uses CNT_WIDTH+1 bits internally; no wrap-around of duty is ever permitted.
- State machine:
  - IDLE (duty==target) goes to UP or DOWN at W when the target differs.
  - UP and DOWN return to IDLE at the W on which duty reaches target.
  - A target reversal mid-ramp switches UP<->DOWN at the next W.
- o_ramping = (state != IDLE), registered.
- o_pwm(t+1) = (cnt(t) < duty(t)). Duty 0 gives constant low; duty=PERIOD gives constant high; no runt pulse on a duty change.
- i_enable falling: duty<=0, state<=IDLE, o_pwm<=0 on the next clock edge, without waiting for W and without ramping down. The counter keeps running.
- i_enable rising: ramps up from 0 at subsequent W events.
- i_level changes between W events: only the value sampled at W matters.
- i_cnt_en low: cnt, duty and state hold, and o_pwm holds its last value.

Optional Feature:
FAN_PWM_KICKSTART_EN. When defined, a W event that starts a ramp from duty==0 to a nonzero target enters state KICK, which applies duty=PERIOD (full on) for KICK_PERIODS periods. It then loads duty=target directly, without ramping, and returns to IDLE. o_ramping is high during KICK. i_enable low aborts KICK immediately. When the macro is undefined, the KICK state and its counter are absent and the behaviour is exactly as above.

Test Plan:
- Reset: with PERIOD=10, i_reset_n low mid-period -> all outputs 0 immediately; cnt=0 after release.
- Duty mapping: RAMP_STEP=0, PERIOD=10, levels 2/4/6, i_cnt_en=1, i_level=2 -> after first W, o_pwm high exactly 4 of every 10 cycles and o_duty=4.
- Ramp up and reversal: RAMP_STEP=3, level 0->3 (target 6) -> o_duty 3 then 6 on successive W with o_ramping 1 then 0; switch to level 1 (2) at duty 3 -> next W gives o_duty=2.
- Enable drop: at duty=6 mid-period, deassert i_enable -> o_pwm=0 next cycle, o_duty=0, o_ramping=0, o_period_tick keeps pulsing every 10 cycles.
- Boundaries: DUTY_L3=PERIOD -> o_pwm constant 1; level 0 -> constant 0; toggle i_cnt_en every other cycle -> period doubles to 20 clocks.
- Kick-start (macro defined, KICK_PERIODS=2): level 0->1 -> o_pwm high for 20 cycles, then o_duty=2 directly.
